// File: rtl/alu_issue_unit.sv
// Execute-stage issue/result controller for an RV32I ALU: S0 decodes and drives the ALU, S1 holds the result.
// Optional ALU_ILLEGAL_TRAP_EN adds an out_illegal flag for unsupported encodings.
module alu_issue_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_opcode,
  input  logic [2:0]            in_funct3,
  input  logic                  in_funct7b5,
  input  logic [DATA_WIDTH-1:0] in_rs1_val,
  input  logic [DATA_WIDTH-1:0] in_rs2_val,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [RD_WIDTH-1:0]   in_rd,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic                  alu_less,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [RD_WIDTH-1:0]   out_rd,
  output logic                  out_we,
  output logic                  out_br_taken,
  output logic [DATA_WIDTH-1:0] out_br_target
`ifdef ALU_ILLEGAL_TRAP_EN
  ,
  output logic                  out_illegal
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SCMP = 4'b1100;
  localparam logic [3:0] ALU_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1011;

  typedef enum logic [1:0] {K_ALU = 2'd0, K_BR = 2'd1, K_ILL = 2'd2} kind_t;

  // Handshake: a side fires on a rising edge where its valid and ready are both high.
  // in_ready = !s0_v | s1_free, s1_free = !s1_v | out_ready; S1 never changes while
  // out_valid & !out_ready.
  logic                  s0_v_q, s0_v_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_b_q, s0_target_q;
  logic [3:0]            alu_op_q;
  kind_t                 s0_kind_q;
  logic [2:0]            s0_f3_q;
  logic [RD_WIDTH-1:0]   s0_rd_q;

  logic                  s1_v_q, s1_v_d;
  logic [DATA_WIDTH-1:0] s1_result_q, s1_target_q;
  logic [RD_WIDTH-1:0]   s1_rd_q;
  logic                  s1_we_q, s1_taken_q;

  logic s1_free, in_fire, s1_load;

  logic [DATA_WIDTH-1:0] dec_a, dec_b;
  logic [3:0]            dec_op;
  kind_t                 dec_kind;

  logic [DATA_WIDTH-1:0] cap_result, cap_target;
  logic [RD_WIDTH-1:0]   cap_rd;
  logic                  cap_we, cap_taken;

  assign s1_free  = !s1_v_q || out_ready;
  assign in_ready = !s0_v_q || s1_free;
  assign in_fire  = in_valid && in_ready;
  assign s1_load  = s0_v_q && s1_free;

  always_comb begin
    dec_a    = '0;
    dec_b    = '0;
    dec_op   = ALU_ADD;
    dec_kind = K_ILL;
    case (in_opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_kind = K_ALU;
        dec_a    = in_rs1_val;
        dec_b    = (in_opcode == OPC_OP) ? in_rs2_val : in_imm;
        case (in_funct3)
          3'b000:  dec_op = (in_opcode == OPC_OP && in_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  dec_op = ALU_SLL;
          3'b010:  dec_op = ALU_SLT;
          3'b011:  dec_op = ALU_SLTU;
          3'b100:  dec_op = ALU_XOR;
          3'b101:  dec_op = in_funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  dec_op = ALU_OR;
          default: dec_op = ALU_AND;
        endcase
        // The ALU shifts by all of B, so only the 5-bit shamt may reach it.
        if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
          dec_b = {{(DATA_WIDTH-5){1'b0}}, dec_b[4:0]};
      end
      OPC_LUI: begin
        dec_kind = K_ALU;
        dec_b    = in_imm;
      end
      OPC_AUIPC: begin
        dec_kind = K_ALU;
        dec_a    = in_pc;
        dec_b    = in_imm;
      end
      OPC_BRANCH: begin
        dec_kind = K_BR;
        dec_a    = in_rs1_val;
        dec_b    = in_rs2_val;
        case (in_funct3)
          3'b000, 3'b001, 3'b110, 3'b111: dec_op = ALU_SUB;
          3'b100, 3'b101:                 dec_op = ALU_SCMP;
          default: begin
            dec_kind = K_ILL;
            dec_a    = '0;
            dec_b    = '0;
          end
        endcase
      end
      default: dec_kind = K_ILL;
    endcase
  end

  always_comb begin
    cap_result = '0;
    cap_target = '0;
    cap_rd     = s0_rd_q;
    cap_we     = 1'b0;
    cap_taken  = 1'b0;
    case (s0_kind_q)
      K_ALU: begin
        cap_result = alu_result;
        cap_we     = (s0_rd_q != '0);
      end
      K_BR: begin
        cap_target = s0_target_q;
        case (s0_f3_q)
          3'b000:         cap_taken = alu_zero;
          3'b001:         cap_taken = !alu_zero;
          3'b100, 3'b110: cap_taken = alu_less;
          default:        cap_taken = !alu_less;
        endcase
      end
      default: cap_rd = '0;
    endcase
  end

  always_comb begin
    s0_v_d = s0_v_q;
    if (in_fire)      s0_v_d = 1'b1;
    else if (s1_load) s0_v_d = 1'b0;
    s1_v_d = s1_free ? s0_v_q : s1_v_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_v_q      <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= ALU_ADD;
      s0_kind_q   <= K_ILL;
      s0_f3_q     <= '0;
      s0_rd_q     <= '0;
      s0_target_q <= '0;
    end else begin
      s0_v_q <= s0_v_d;
      if (in_fire) begin
        alu_a_q     <= dec_a;
        alu_b_q     <= dec_b;
        alu_op_q    <= dec_op;
        s0_kind_q   <= dec_kind;
        s0_f3_q     <= in_funct3;
        s0_rd_q     <= in_rd;
        s0_target_q <= in_pc + in_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_result_q <= '0;
      s1_target_q <= '0;
      s1_rd_q     <= '0;
      s1_we_q     <= 1'b0;
      s1_taken_q  <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      if (s1_load) begin
        s1_result_q <= cap_result;
        s1_target_q <= cap_target;
        s1_rd_q     <= cap_rd;
        s1_we_q     <= cap_we;
        s1_taken_q  <= cap_taken;
      end
    end
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  logic s1_ill_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       s1_ill_q <= 1'b0;
    else if (s1_load) s1_ill_q <= (s0_kind_q == K_ILL);
  end
  assign out_illegal = s1_ill_q;
`endif

  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign out_valid     = s1_v_q;
  assign out_result    = s1_result_q;
  assign out_rd        = s1_rd_q;
  assign out_we        = s1_we_q;
  assign out_br_taken  = s1_taken_q;
  assign out_br_target = s1_target_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU, directed vectors, expected-queue scoreboard.
// Build with ALU_ILLEGAL_TRAP_EN to also check out_illegal.
module tb_alu_issue_unit;

  localparam int EW = 72; // {illegal, target[31:0], taken, we, rd[4:0], result[31:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero, alu_less;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result, out_br_target;
  logic [4:0]  out_rd;
  logic        out_we, out_br_taken;
`ifdef ALU_ILLEGAL_TRAP_EN
  logic        out_illegal;
`endif

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int pops = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  logic saw_stall = 1'b0;

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
    .in_pc(in_pc), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_br_taken(out_br_taken), .out_br_target(out_br_target)
`ifdef ALU_ILLEGAL_TRAP_EN
    , .out_illegal(out_illegal)
`endif
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference RV32I ALU sitting outside the DUT
  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b0010: alu_result = alu_a ^ alu_b;
      4'b0011: alu_result = alu_a | alu_b;
      4'b0100: alu_result = alu_a & alu_b;
      4'b0101: alu_result = alu_a << alu_b;
      4'b0110: alu_result = alu_a >> alu_b;
      4'b0111: alu_result = $unsigned($signed(alu_a) >>> alu_b);
      4'b1100: alu_result = alu_a - alu_b;
      4'b1101: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b1011: alu_result = {31'b0, alu_a < alu_b};
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);
  assign alu_less = (alu_op[3:2] == 2'b11) ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic ill, input logic [31:0] tgt, input logic tk,
                                        input logic we, input logic [4:0] rd, input logic [31:0] res);
    return {ill, tgt, tk, we, rd, res};
  endfunction

  // Driver: call at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                      input logic [31:0] pc, input logic [4:0] rd, input logic [EW-1:0] e);
    int n;
    n = 0;
    in_valid = 1'b1; in_opcode = opc; in_funct3 = f3; in_funct7b5 = f7;
    in_rs1_val = a; in_rs2_val = b; in_imm = imm; in_pc = pc; in_rd = rd;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=in_ready_low expected=accept_within_100");
    end else begin
      exp_q.push_back(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst_n && in_valid && !in_ready) saw_stall = 1'b1;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=result_%h expected=no_output", out_result);
      end else begin
        e = exp_q.pop_front();
        chk("out_result", out_result, e[31:0]);
        chk("out_rd", {27'b0, out_rd}, {27'b0, e[36:32]});
        chk("out_we", {31'b0, out_we}, {31'b0, e[37]});
        chk("out_br_taken", {31'b0, out_br_taken}, {31'b0, e[38]});
        chk("out_br_target", out_br_target, e[70:39]);
`ifdef ALU_ILLEGAL_TRAP_EN
        chk("out_illegal", {31'b0, out_illegal}, {31'b0, e[71]});
`endif
        pops++;
        last_pop_cyc = cyc;
      end
    end
  end

  initial begin
    int start_cyc;
    int pops_before;
    int n;
    // Reset state while held
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: add with latency
    send(7'b0110011, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, mk(0, 0, 0, 1, 5'd3, 32'd12));
    chk("add_alu_op", {28'b0, alu_op}, 32'h0);
    chk("add_latency_n1", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    chk("add_latency_n2", {31'b0, out_valid}, 32'd1);

    // 2: srai with shamt masking
    send(7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'd0, 5'd5,
         mk(0, 0, 0, 1, 5'd5, 32'hF800_0000));
    chk("srai_alu_b", alu_b, 32'd4);
    chk("srai_alu_op", {28'b0, alu_op}, 32'h7);

    // 3: branches
    send(7'b1100011, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0,
         mk(0, 32'h120, 1, 0, 5'd0, 32'd0));
    chk("blt_alu_op", {28'b0, alu_op}, 32'hC);
    send(7'b1100011, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0,
         mk(0, 32'h120, 0, 0, 5'd0, 32'd0));
    chk("bltu_alu_op", {28'b0, alu_op}, 32'h1);
    send(7'b1100011, 3'b000, 1'b0, 32'd9, 32'd9, 32'hFFFF_FFF0, 32'h200, 5'd0,
         mk(0, 32'h1F0, 1, 0, 5'd0, 32'd0));
    send(7'b1100011, 3'b001, 1'b0, 32'd9, 32'd9, 32'h8, 32'h200, 5'd0,
         mk(0, 32'h208, 0, 0, 5'd0, 32'd0));
    send(7'b1100011, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 5'd0,
         mk(0, 32'h340, 0, 0, 5'd0, 32'd0));
    send(7'b1100011, 3'b111, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h300, 5'd0,
         mk(0, 32'h340, 0, 0, 5'd0, 32'd0));

    // Assorted ALU forms
    send(7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 5'd4, mk(0, 0, 0, 1, 5'd4, 32'hFFFF_FFFE));
    send(7'b0110011, 3'b001, 1'b0, 32'd3, 32'h21, 32'd0, 32'd0, 5'd6, mk(0, 0, 0, 1, 5'd6, 32'd6));
    chk("sll_alu_b", alu_b, 32'd1);
    send(7'b0010011, 3'b100, 1'b0, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd7,
         mk(0, 0, 0, 1, 5'd7, 32'h0F0F_0F0F));
    send(7'b0010011, 3'b010, 1'b0, 32'hFFFF_FFFB, 32'd0, 32'd2, 32'd0, 5'd8, mk(0, 0, 0, 1, 5'd8, 32'd1));
    send(7'b0110011, 3'b011, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd9, mk(0, 0, 0, 1, 5'd9, 32'd1));
    send(7'b0110111, 3'b000, 1'b0, 32'd77, 32'd0, 32'hABCD_E000, 32'd0, 5'd10,
         mk(0, 0, 0, 1, 5'd10, 32'hABCD_E000));
    send(7'b0010111, 3'b000, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd11, mk(0, 0, 0, 1, 5'd11, 32'h3000));
    send(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd0, mk(0, 0, 0, 0, 5'd0, 32'd2));

    // 6: unsupported opcode (load) and branch funct3 010
    send(7'b0000011, 3'b010, 1'b0, 32'd100, 32'd0, 32'd4, 32'd0, 5'd12, mk(1, 0, 0, 0, 5'd0, 32'd0));
    send(7'b1100011, 3'b010, 1'b0, 32'd1, 32'd2, 32'd4, 32'h40, 5'd13, mk(1, 0, 0, 0, 5'd0, 32'd0));
    repeat (3) @(negedge clk);

    // Full throughput: four adds, one result per cycle
    start_cyc = cyc;
    for (int i = 0; i < 4; i++)
      send(7'b0110011, 3'b000, 1'b0, 32'd10 * i, 32'd1, 32'd0, 32'd0, 5'(i + 1),
           mk(0, 0, 0, 1, 5'(i + 1), 32'd10 * i + 32'd1));
    repeat (2) @(negedge clk);
    chk("throughput_last_pop", last_pop_cyc, start_cyc + 5);

    // 4: back-pressure mid-stream
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(7'b0110011, 3'b000, 1'b0, 32'h100 + i, 32'h1000, 32'd0, 32'd0, 5'(i + 20),
               mk(0, 0, 0, 1, 5'(i + 20), 32'h1100 + i));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_drained", exp_q.size(), 32'd0);
    chk("bp_in_ready_fell", {31'b0, saw_stall}, 32'd1);

    // 5: reset while both stages hold work
    out_ready = 1'b0;
    send(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd1, mk(0, 0, 0, 1, 5'd1, 32'd3));
    send(7'b0110011, 3'b000, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 5'd2, mk(0, 0, 0, 1, 5'd2, 32'd7));
    chk("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    chk("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_we", {31'b0, out_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    pops_before = pops;
    @(negedge clk);
    chk("postrst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (5) @(negedge clk);
    chk("postrst_no_output", pops, pops_before);

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
